uart_char_rx: RTL
=================

UART_CHAR_RX -- requirements
Module: uart_char_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-005 SHALL have port latched_value  output  8  last received character byte.
REQ-006 SHALL have port btn_pressed  output  1  one-cycle strobe marking latched_value as newly valid.
REQ-007 SHALL have port frame_err  output  1  one-cycle strobe marking a frame with a bad stop bit.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, with both flops resetting to 1; all logic uses the synchronized value rx_s.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-timer counter wide enough for CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-011 IDLE: on rx_s = 0, SHALL go to START with timer cleared.
REQ-012 START: at timer = (CLKS_PER_BIT-1)/2 (integer divide), SHALL resample rx_s. If 0, go to DATA with timer and bit index cleared. If 1, treat it as a glitch and return to IDLE with no strobe.
REQ-013 DATA: at each timer = CLKS_PER_BIT-1, SHALL shift rx_s into bit [index] of the shift register, clear the timer, and increment the index. After index 7 is sampled, go to STOP.
REQ-014 STOP: at timer = CLKS_PER_BIT-1, SHALL sample rx_s and return to IDLE.
  - If 1, load latched_value with the shift register and pulse btn_pressed for exactly 1 cycle.
  - If 0, pulse frame_err for 1 cycle and leave latched_value unchanged.
REQ-015 Net effect: data bits are sampled at bit centres, and the stop bit is sampled one full bit after the last data centre.
REQ-016 btn_pressed and frame_err SHALL be registered and asserted in the cycle after the stop sample; they are never both high.
REQ-017 latched_value SHALL hold its value between strobes and update only together with btn_pressed.
REQ-018 After a framing error, SHALL NOT re-arm until rx_s has been seen high in IDLE (break condition: no repeated frame_err while the line is held low).
REQ-019 A start edge arriving immediately after STOP returns to IDLE SHALL be accepted (back-to-back frames, zero idle gap).
REQ-020 SHALL NOT filter byte values; any 8-bit value, including values above 0x7A, is passed through with btn_pressed.
REQ-021 busy SHALL be combinationally derived from state and go low in the same cycle the FSM re-enters IDLE.

Reset
REQ-022 Asserting reset SHALL immediately force:
  - state = IDLE
  - timer = 0, index = 0
  - shift register = 0x00, latched_value = 0x00
  - btn_pressed = 0, frame_err = 0, busy = 0
  - synchronizer flops = 1
REQ-023 Reset asserted mid-frame SHALL abort the frame with no strobe. After release, the remainder of the aborted frame SHALL NOT produce btn_pressed unless a valid start bit is subsequently detected.

Verification (CLKS_PER_BIT = 16 in simulation)
REQ-024 Send 0x41 as 8N1 -> exactly one btn_pressed pulse, latched_value = 0x41, frame_err stays 0, busy high for about 160 cycles.
REQ-025 Send 0x48 then 0x69 back-to-back with zero idle gap -> two btn_pressed pulses, latched_value 0x48 then 0x69.
REQ-026 Send 0x7F with stop bit forced 0 -> frame_err pulses once, no btn_pressed, latched_value keeps its prior value. Holding rx low for a further 400 cycles -> no additional strobes.
REQ-027 Pulse rx low for 4 cycles (shorter than half a bit) -> returns to IDLE, no strobes, busy low again within 10 cycles.
REQ-028 Assert reset at data bit 3 of a 0x55 frame, release it, then send 0x5A -> outputs zero during reset, no strobe for 0x55, single btn_pressed with latched_value = 0x5A.
REQ-029 Send 0xFF followed by 0x00 -> btn_pressed for both bytes, latched_value = 0xFF then 0x00.

Source files
------------

// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver: synchronizes rx, samples each bit at its centre,
// and latches the byte with a one-cycle strobe (or flags a bad stop bit).
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] latched_value,
  output logic       btn_pressed,
  output logic       frame_err,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic              rx_p0;
  logic              rx_s;
  logic [1:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic              break_hold;

  // stage p0 -> rx_s: two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // frame FSM; break_hold blocks re-arming until the line returns high after a framing error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= 3'd0;
      shift_q       <= '0;
      latched_value <= '0;
      btn_pressed   <= 1'b0;
      frame_err     <= 1'b0;
      break_hold    <= 1'b0;
    end else begin
      btn_pressed <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (break_hold) begin
            if (rx_s) break_hold <= 1'b0;
          end else if (!rx_s) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == HALF_BIT) begin
            if (!rx_s) begin
              state   <= DATA;
              timer   <= '0;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_END) begin
            shift_q[bit_idx] <= rx_s;
            timer            <= '0;
            bit_idx          <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == BIT_END) begin
            state <= IDLE;
            timer <= '0;
            if (rx_s) begin
              latched_value <= shift_q;
              btn_pressed   <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
              break_hold <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
